// File: rtl/m68k_bus_ctrl_pkg.sv
// Shared types and constants for the 68000 bus front end.
package m68k_bus_ctrl_pkg;

   localparam int unsigned ADDR_W      = 23;
   localparam int unsigned DATA_W      = 16;
   localparam int unsigned TIMEOUT_DEF = 1024;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      ACK  = 2'd2,
      ERR  = 2'd3
   } bus_state_t;

endpackage

// File: rtl/m68k_bus_ctrl_sync_ff.sv
// Multi-stage synchroniser for one asynchronous input, preset to a chosen level on reset.
module sync_ff #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic        RST_VAL     = 1'b1
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic d_i,
   output logic q_o
);

   logic [SYNC_STAGES-1:0] chain_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         chain_q <= {SYNC_STAGES{RST_VAL}};
      end else begin
         chain_q[0] <= d_i;
         for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            chain_q[i] <= chain_q[i-1];
         end
      end
   end

   assign q_o = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/m68k_bus_ctrl.sv
// 68000 pin front end: synchronises strobes, issues one registered bus request per
// CPU cycle, waits for the decoder slot grant and answers with _dtack (or _berr on timeout).
module m68k_bus_ctrl
   import m68k_bus_ctrl_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned TIMEOUT     = TIMEOUT_DEF,
   parameter int unsigned TOW         = 10
) (
   input  logic              clk,
   input  logic              _reset,
   input  logic              _as,
   input  logic              _uds,
   input  logic              _lds,
   input  logic              r_w,
   input  logic [ADDR_W-1:0] cpupins_addr,
   input  logic [DATA_W-1:0] cpupins_din,
   output logic [DATA_W-1:0] cpupins_dout,
   output logic              _dtack,
   output logic              _berr,
   output logic [ADDR_W-1:0] cpuaddress,
   output logic              cpurd,
   output logic              cpuhwr,
   output logic              cpulwr,
   input  logic              cpuok,
   input  logic [DATA_W-1:0] datain,
   output logic [DATA_W-1:0] dataout
);

   localparam logic [TOW-1:0] CNT_LAST = TOW'(TIMEOUT - 1);

   logic as_s, uds_s, lds_s, rw_s;

   sync_ff #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_as (
      .clk_i(clk), .rst_n_i(_reset), .d_i(_as), .q_o(as_s));
   sync_ff #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_uds (
      .clk_i(clk), .rst_n_i(_reset), .d_i(_uds), .q_o(uds_s));
   sync_ff #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_lds (
      .clk_i(clk), .rst_n_i(_reset), .d_i(_lds), .q_o(lds_s));
   sync_ff #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_rw (
      .clk_i(clk), .rst_n_i(_reset), .d_i(r_w), .q_o(rw_s));

   bus_state_t        state_q, state_d;
   logic [TOW-1:0]    cnt_q, cnt_d;
   logic              rd_q, rd_d, hwr_q, hwr_d, lwr_q, lwr_d;
   logic              dtack_n_q, dtack_n_d, berr_n_q, berr_n_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;

   always_ff @(posedge clk or negedge _reset) begin
      if (!_reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         rd_q      <= 1'b0;
         hwr_q     <= 1'b0;
         lwr_q     <= 1'b0;
         dtack_n_q <= 1'b1;
         berr_n_q  <= 1'b1;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rd_q      <= rd_d;
         hwr_q     <= hwr_d;
         lwr_q     <= lwr_d;
         dtack_n_q <= dtack_n_d;
         berr_n_q  <= berr_n_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rd_d      = rd_q;
      hwr_d     = hwr_q;
      lwr_d     = lwr_q;
      dtack_n_d = dtack_n_q;
      berr_n_d  = berr_n_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      case (state_q)
         IDLE: begin
            if (!as_s && (!uds_s || !lds_s)) begin
               addr_d = cpupins_addr;
               if (rw_s) begin
                  rd_d = 1'b1;
               end else begin
                  hwr_d   = ~uds_s;
                  lwr_d   = ~lds_s;
                  wdata_d = cpupins_din;
               end
               cnt_d   = '0;
               state_d = REQ;
            end
         end
         REQ: begin
            // Strobe changes are ignored here: once requested, the slot is seen through.
            if (cpuok) begin
               if (rd_q) rdata_d = datain;
               rd_d      = 1'b0;
               hwr_d     = 1'b0;
               lwr_d     = 1'b0;
               dtack_n_d = 1'b0;
               state_d   = ACK;
            end else if (cnt_q == CNT_LAST) begin
               rd_d     = 1'b0;
               hwr_d    = 1'b0;
               lwr_d    = 1'b0;
               berr_n_d = 1'b0;
               state_d  = ERR;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + TOW'(1);
            end
         end
         ACK: begin
            // Only the data strobes release the ack so a TAS can re-enter with _as still low.
            if (uds_s && lds_s) begin
               dtack_n_d = 1'b1;
               state_d   = IDLE;
            end
         end
         ERR: begin
            if (as_s) begin
               berr_n_d = 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign cpupins_dout = rdata_q;
   assign _dtack       = dtack_n_q;
   assign _berr        = berr_n_q;
   assign cpuaddress   = addr_q;
   assign cpurd        = rd_q;
   assign cpuhwr       = hwr_q;
   assign cpulwr       = lwr_q;
   assign dataout      = wdata_q;

endmodule

// File: tb/tb_m68k_bus_ctrl.sv
// Directed bench for m68k_bus_ctrl with a 16-cycle watchdog; expectations are hand-derived.
module tb_m68k_bus_ctrl;

   logic        clk = 1'b0;
   logic        _reset;
   logic        _as, _uds, _lds, r_w;
   logic [22:0] cpupins_addr;
   logic [15:0] cpupins_din;
   logic [15:0] cpupins_dout;
   logic        _dtack, _berr;
   logic [22:0] cpuaddress;
   logic        cpurd, cpuhwr, cpulwr;
   logic        cpuok;
   logic [15:0] datain;
   logic [15:0] dataout;

   int total = 0;
   int bad   = 0;

   m68k_bus_ctrl #(.SYNC_STAGES(2), .TIMEOUT(16), .TOW(4)) dut (
      .clk(clk), ._reset(_reset), ._as(_as), ._uds(_uds), ._lds(_lds), .r_w(r_w),
      .cpupins_addr(cpupins_addr), .cpupins_din(cpupins_din), .cpupins_dout(cpupins_dout),
      ._dtack(_dtack), ._berr(_berr), .cpuaddress(cpuaddress), .cpurd(cpurd),
      .cpuhwr(cpuhwr), .cpulwr(cpulwr), .cpuok(cpuok), .datain(datain), .dataout(dataout)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_cycle(input logic rw, input logic uds, input logic lds,
                              input logic [22:0] a, input logic [15:0] d);
      cpupins_addr = a;
      cpupins_din  = d;
      r_w          = rw;
      _uds         = uds;
      _lds         = lds;
      _as          = 1'b0;
   endtask

   // Releases the strobes and returns how many clocks until both _dtack and _berr are high.
   task automatic release_wait(input logic keep_as, output int n);
      _uds = 1'b1;
      _lds = 1'b1;
      if (!keep_as) _as = 1'b1;
      n = 0;
      while (n < 10 && (_dtack !== 1'b1 || _berr !== 1'b1)) begin
         tick();
         n++;
      end
      if (_dtack !== 1'b1 || _berr !== 1'b1) n = 99;
   endtask

   task automatic test_reset();
      #12;
      if (_dtack !== 1'b1) begin $display("FAIL rst_dtack got=%b want=1", _dtack); bad++; end
      total++;
      if (_berr !== 1'b1) begin $display("FAIL rst_berr got=%b want=1", _berr); bad++; end
      total++;
      if ({cpurd, cpuhwr, cpulwr} !== 3'b000) begin
         $display("FAIL rst_req got=%b want=000", {cpurd, cpuhwr, cpulwr}); bad++; end
      total++;
      if (cpuaddress !== 23'h0) begin $display("FAIL rst_addr got=%h want=0", cpuaddress); bad++; end
      total++;
      if (dataout !== 16'h0) begin $display("FAIL rst_dataout got=%h want=0", dataout); bad++; end
      total++;
      if (cpupins_dout !== 16'h0) begin $display("FAIL rst_dout got=%h want=0", cpupins_dout); bad++; end
      total++;
      tick();
      _reset = 1'b1;
      tick();
      tick();
   endtask

   task automatic test_read();
      int first = 0, rdcnt = 0, n;
      tick();
      start_cycle(1'b1, 1'b0, 1'b0, 23'h7E0002, 16'h0000);
      datain = 16'h4AFC;
      cpuok  = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         tick();
         if (cpurd === 1'b1) rdcnt++;
         if (_dtack === 1'b0 && first == 0) first = i;
      end
      if (first != 4) begin $display("FAIL read_latency got=%0d want=4", first); bad++; end
      total++;
      if (rdcnt != 1) begin $display("FAIL read_rd_pulse got=%0d want=1", rdcnt); bad++; end
      total++;
      if (cpupins_dout !== 16'h4AFC) begin $display("FAIL read_data got=%h want=4afc", cpupins_dout); bad++; end
      total++;
      if (cpuaddress !== 23'h7E0002) begin $display("FAIL read_addr got=%h want=7e0002", cpuaddress); bad++; end
      total++;
      if (dataout !== 16'h0) begin $display("FAIL read_no_wdata got=%h want=0", dataout); bad++; end
      total++;
      if (_dtack !== 1'b0) begin $display("FAIL read_dtack_held got=%b want=0", _dtack); bad++; end
      total++;
      cpuok = 1'b0;
      release_wait(1'b0, n);
      if (n < 2 || n > 3) begin $display("FAIL read_release got=%0d want=2..3", n); bad++; end
      total++;
   endtask

   task automatic test_write_lower();
      int first = 0, lw = 0, hw = 0, unstable = 0, n;
      tick();
      start_cycle(1'b0, 1'b1, 1'b0, 23'h6FF8C0, 16'h0F00);
      cpuok = 1'b0;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (cpulwr === 1'b1) lw++;
         if (cpuhwr === 1'b1) hw++;
         if (_dtack === 1'b0 && first == 0) first = i;
         if (i >= 3 && (dataout !== 16'h0F00 || cpuaddress !== 23'h6FF8C0)) unstable++;
         if (i == 8) cpuok = 1'b1;
      end
      if (lw != 6) begin $display("FAIL wr_lwr_len got=%0d want=6", lw); bad++; end
      total++;
      if (hw != 0) begin $display("FAIL wr_hwr_len got=%0d want=0", hw); bad++; end
      total++;
      if (unstable != 0) begin $display("FAIL wr_latch_stable got=%0d want=0", unstable); bad++; end
      total++;
      if (first != 9) begin $display("FAIL wr_dtack_at got=%0d want=9", first); bad++; end
      total++;
      if (cpupins_dout !== 16'h4AFC) begin $display("FAIL wr_dout_kept got=%h want=4afc", cpupins_dout); bad++; end
      total++;
      cpuok = 1'b0;
      release_wait(1'b0, n);
      if (n != 3) begin $display("FAIL wr_release got=%0d want=3", n); bad++; end
      total++;
   endtask

   task automatic test_timeout();
      int first = 0, dt = 0, hw = 0, n;
      tick();
      start_cycle(1'b0, 1'b0, 1'b1, 23'h000123, 16'hBEEF);
      cpuok = 1'b0;
      for (int i = 1; i <= 24; i++) begin
         tick();
         if (_berr === 1'b0 && first == 0) first = i;
         if (_dtack === 1'b0) dt++;
         if (cpuhwr === 1'b1) hw++;
      end
      if (first != 19) begin $display("FAIL to_berr_at got=%0d want=19", first); bad++; end
      total++;
      if (hw != 16) begin $display("FAIL to_req_len got=%0d want=16", hw); bad++; end
      total++;
      if ({cpurd, cpuhwr, cpulwr} !== 3'b000) begin
         $display("FAIL to_req_off got=%b want=000", {cpurd, cpuhwr, cpulwr}); bad++; end
      total++;
      release_wait(1'b0, n);
      if (n != 3) begin $display("FAIL to_berr_release got=%0d want=3", n); bad++; end
      total++;
      if (dt != 0) begin $display("FAIL to_no_dtack got=%0d want=0", dt); bad++; end
      total++;
   endtask

   task automatic test_race();
      int first = 0, be = 0, n;
      tick();
      start_cycle(1'b1, 1'b0, 1'b0, 23'h0ABCDE, 16'h0000);
      datain = 16'h1234;
      cpuok  = 1'b0;
      for (int i = 1; i <= 22; i++) begin
         tick();
         if (_dtack === 1'b0 && first == 0) first = i;
         if (_berr === 1'b0) be++;
         if (i == 18) cpuok = 1'b1;
      end
      if (first != 19) begin $display("FAIL race_dtack_at got=%0d want=19", first); bad++; end
      total++;
      if (be != 0) begin $display("FAIL race_berr got=%0d want=0", be); bad++; end
      total++;
      if (cpupins_dout !== 16'h1234) begin $display("FAIL race_data got=%h want=1234", cpupins_dout); bad++; end
      total++;
      cpuok = 1'b0;
      release_wait(1'b0, n);
      if (n != 3) begin $display("FAIL race_release got=%0d want=3", n); bad++; end
      total++;
   endtask

   task automatic test_back_to_back_tas();
      int first = 0, rd = 0, wr = 0, n;
      tick();
      start_cycle(1'b1, 1'b0, 1'b0, 23'h001000, 16'h0000);
      datain = 16'h00FF;
      cpuok  = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         tick();
         if (cpurd === 1'b1) rd++;
         if (_dtack === 1'b0 && first == 0) first = i;
      end
      if (rd != 1 || first != 4) begin
         $display("FAIL tas_read got=rd%0d/at%0d want=rd1/at4", rd, first); bad++; end
      total++;
      release_wait(1'b1, n);
      if (n != 3) begin $display("FAIL tas_mid_release got=%0d want=3", n); bad++; end
      total++;
      r_w         = 1'b0;
      cpupins_din = 16'h0080;
      _uds        = 1'b0;
      _lds        = 1'b0;
      first = 0; rd = 0;
      for (int i = 1; i <= 6; i++) begin
         tick();
         if (cpurd === 1'b1) rd++;
         if (cpuhwr === 1'b1 && cpulwr === 1'b1) wr++;
         if (_dtack === 1'b0 && first == 0) first = i;
      end
      if (rd != 0 || wr != 1 || first != 4) begin
         $display("FAIL tas_write got=rd%0d/wr%0d/at%0d want=rd0/wr1/at4", rd, wr, first); bad++; end
      total++;
      if (dataout !== 16'h0080) begin $display("FAIL tas_wdata got=%h want=0080", dataout); bad++; end
      total++;
      cpuok = 1'b0;
      release_wait(1'b0, n);
      if (n != 3) begin $display("FAIL tas_release got=%0d want=3", n); bad++; end
      total++;
   endtask

   task automatic test_reset_mid();
      int first = 0, n;
      tick();
      start_cycle(1'b0, 1'b0, 1'b1, 23'h055555, 16'hA5A5);
      cpuok = 1'b0;
      for (int i = 1; i <= 5; i++) tick();
      if (cpuhwr !== 1'b1) begin $display("FAIL rmid_pre_hwr got=%b want=1", cpuhwr); bad++; end
      total++;
      #2;
      _reset = 1'b0;
      #1;
      if ({cpurd, cpuhwr, cpulwr, _dtack, _berr} !== 5'b00011) begin
         $display("FAIL rmid_ctrl got=%b want=00011", {cpurd, cpuhwr, cpulwr, _dtack, _berr}); bad++; end
      total++;
      if (cpuaddress !== 23'h0 || dataout !== 16'h0 || cpupins_dout !== 16'h0) begin
         $display("FAIL rmid_data got=%h/%h/%h want=0/0/0", cpuaddress, dataout, cpupins_dout); bad++; end
      total++;
      _as = 1'b1; _uds = 1'b1; _lds = 1'b1;
      tick();
      tick();
      _reset = 1'b1;
      tick();
      start_cycle(1'b1, 1'b0, 1'b0, 23'h7E0002, 16'h0000);
      datain = 16'hC0DE;
      cpuok  = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         tick();
         if (_dtack === 1'b0 && first == 0) first = i;
      end
      if (first != 4) begin $display("FAIL rmid_after_latency got=%0d want=4", first); bad++; end
      total++;
      if (cpupins_dout !== 16'hC0DE) begin $display("FAIL rmid_after_data got=%h want=c0de", cpupins_dout); bad++; end
      total++;
      cpuok = 1'b0;
      release_wait(1'b0, n);
      if (n != 3) begin $display("FAIL rmid_after_release got=%0d want=3", n); bad++; end
      total++;
   endtask

   initial begin
      _reset       = 1'b0;
      _as          = 1'b1;
      _uds         = 1'b1;
      _lds         = 1'b1;
      r_w          = 1'b1;
      cpupins_addr = '0;
      cpupins_din  = '0;
      cpuok        = 1'b0;
      datain       = '0;
      test_reset();
      test_read();
      test_write_lower();
      test_timeout();
      test_race();
      test_back_to_back_tas();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=stalled want=finished");
      $fatal(1);
   end

endmodule

// File: doc/m68k_bus_ctrl.md
Name: m68k_bus_ctrl

Overview:
- Front end between the 68000 pins and the bus decoder/arbiter (gary).
- Synchronises the asynchronous 68000 strobes and latches address and write data.
- Drives the registered `cpurd`/`cpuhwr`/`cpulwr` requests that the decoder qualifies, waits for the decoder's `cpuok` slot grant, then captures read data and answers the CPU with `_dtack`.
- A watchdog terminates a cycle that never gets a slot with `_berr`.

Parameters:
- SYNC_STAGES, 2: synchroniser flops on `_as`, `_uds`, `_lds`, `r_w`.
- TIMEOUT, 1024: clk cycles in REQ without `cpuok` before bus error.
- TOW, 10: timeout counter width, ceil(log2(TIMEOUT)).

Ports:
- clk  in  1  bus clock (same clock as decoder).
- _reset  in  1  asynchronous, active-low reset.
- _as  in  1  68000 address strobe, asynchronous.
- _uds  in  1  68000 upper data strobe, asynchronous.
- _lds  in  1  68000 lower data strobe, asynchronous.
- r_w  in  1  68000 read(1)/write(0).
- cpupins_addr  in  23  68000 A[23:1].
- cpupins_din  in  16  68000 data bus, write data.
- cpupins_dout  out  16  read data returned to the CPU.
- _dtack  out  1  data acknowledge, active low.
- _berr  out  1  bus error, active low.
- cpuaddress  out  23  latched A[23:1]; bits [23:12] feed the decoder.
- cpurd  out  1  bus read request to decoder.
- cpuhwr  out  1  bus high-byte write request.
- cpulwr  out  1  bus low-byte write request.
- cpuok  in  1  slot grant from decoder (combinational on its side).
- datain  in  16  chip bus read data, valid in the `cpuok` cycle.
- dataout  out  16  latched write data to chip bus.

Behaviour:
- Reset: async on `_reset`=0. State=IDLE; `_dtack`=1, `_berr`=1; `cpurd`/`cpuhwr`/`cpulwr`=0; `cpuaddress`=0, `dataout`=0, `cpupins_dout`=0; timeout counter=0; synchronisers preset to the inactive level (strobes 1, `r_w` 1). Reset mid-cycle abandons the cycle immediately with no ack.
- Synchronised signals are named `as_s`, `uds_s`, `lds_s`, `rw_s`.
- States: IDLE, REQ, ACK, ERR.
- IDLE:
  - Start condition: `as_s`=0 and (`uds_s`=0 or `lds_s`=0).
  - On start, latch `cpuaddress`, `dataout` (writes only), and the request.
  - Request on read (`rw_s`=1): `cpurd`=1.
  - Request on write: `cpuhwr`=~`uds_s`, `cpulwr`=~`lds_s`.
  - Clear the counter and go to REQ.
  - Request outputs are registered, so they are asserted from the clock after start.
- REQ:
  - Requests are held stable.
  - At an edge with `cpuok`=1, capture `datain` into `cpupins_dout` (reads only), drop all requests, set `_dtack`=0, go to ACK. Exactly one bus slot is consumed.
  - Else the counter increments.
  - At counter == TIMEOUT-1 with `cpuok`=0: drop requests, set `_berr`=0, go to ERR.
  - `cpuok` and timeout in the same cycle: `cpuok` wins.
- ACK:
  - `_dtack` is held low and `cpupins_dout` held stable.
  - When `uds_s`=1 and `lds_s`=1, set `_dtack`=1 and go to IDLE.
  - `_as` may stay low, so a read-modify-write (TAS) starts a second cycle from IDLE when the strobes fall again.
- ERR:
  - `_berr` is held low until `as_s`=1; then `_berr`=1 and go to IDLE.
- Other rules:
  - Latency: `_dtack` falls SYNC_STAGES+2 clocks after the `_as`/strobe fall when `cpuok`=1 on the first REQ cycle. Each extra `cpuok`=0 cycle adds one clock.
  - Strobes rising while in REQ (CPU aborted) are ignored. The cycle completes or times out, then returns to IDLE via the ACK/ERR release rules.
  - At most one of `cpurd` or {`cpuhwr`,`cpulwr`} is asserted at any time. All requests are 0 outside REQ.
  - Counter saturates and never wraps.
  - `cpuaddress` and `dataout` change only on the IDLE→REQ edge.

Decomposition:
- Shared package: state encoding constants (IDLE, REQ, ACK, ERR), bus width constants (ADDR_W=23, DATA_W=16), default TIMEOUT.
- One natural sub-module, `sync_ff`: parameterised SYNC_STAGES flop chain with async active-low reset and a reset-value parameter. Instantiated for `_as`, `_uds`, `_lds`, `r_w`.

Test Plan:
- Read word $FC0004, `cpuok`=1 immediately, `datain`=$4AFC:
  - `cpurd` is high exactly 1 clock.
  - `_dtack` low 4 clocks after `_as` fall.
  - `cpupins_dout`=$4AFC.
  - `_dtack` rises 2–3 clocks after strobes release.
- Lower-byte write $DFF180, data $0F00, `cpuok` held 0 for 5 cycles then 1:
  - `cpulwr`=1 and `cpuhwr`=0 for 6 clocks.
  - `dataout`=$0F00 and `cpuaddress`=$6FF8C0 stable throughout.
  - `_dtack` follows.
- Timeout with TIMEOUT=16 and `cpuok` stuck 0:
  - `_berr` low 16 clocks after REQ entry; requests 0.
  - `_berr` returns high after `_as` rises; `_dtack` never asserted.
- TAS, `_as` held low with read strobe, release, then write strobe:
  - Two distinct REQ cycles.
  - `cpurd` pulse then `cpuhwr`/`cpulwr` pulse, each acknowledged.
- `_reset` pulled low while in REQ with `cpuhwr`=1:
  - All outputs return to reset values asynchronously, with no clock edge needed.
  - After release, the next cycle completes normally.
- `cpuok`=1 on the same edge the counter hits TIMEOUT-1:
  - ACK is taken and `_berr` stays 1.
